// File: rtl/oled_fb_pkg.sv
// Shared constants, state encoding and RGB565 helpers for the OLED frame-buffer reader.
package oled_fb_pkg;

    localparam int OLED_W   = 96;
    localparam int OLED_H   = 64;
    localparam int IMG_W    = 80;
    localparam int IMG_H    = 60;
    localparam int WIN_COL0 = 8;
    localparam int WIN_ROW0 = 2;

    // RGB565 layout: outer fields are 5 bits, the middle field is 6 bits
    localparam int RB_W  = 5;
    localparam int MID_W = 6;

    typedef enum logic [2:0] {
        FETCH,
        HOLD,
        WAIT,
        LATCH,
        READY
    } fb_state_t;

    function automatic logic [15:0] swap565(input logic [15:0] p);
        return {p[RB_W-1:0], p[RB_W+MID_W-1:RB_W], p[15:RB_W+MID_W]};
    endfunction

endpackage

// File: rtl/oled_fb_reader_scan.sv
// OLED scan position counter: col fastest, wraps after the last row, and
// reports where the current position sits relative to the image window.
module oled_scan_counter #(
    parameter int OLED_COLS = 96,
    parameter int OLED_ROWS = 64,
    parameter int IMG_COLS  = 80,
    parameter int IMG_ROWS  = 60,
    parameter int COL_OFS   = 8,
    parameter int ROW_OFS   = 2
) (
    input  logic oclk,
    input  logic rst,
    input  logic advance,
    output logic at_origin,
    output logic in_win,
    output logic first_win,
    output logic last_win
);

    localparam int CW = $clog2(OLED_COLS);
    localparam int RW = $clog2(OLED_ROWS);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    always_ff @(posedge oclk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col == CW'(OLED_COLS - 1)) begin
                col <= '0;
                row <= (row == RW'(OLED_ROWS - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_comb begin
        at_origin = (col == '0) && (row == '0);
        in_win    = (int'(col) >= COL_OFS) && (int'(col) < COL_OFS + IMG_COLS) &&
                    (int'(row) >= ROW_OFS) && (int'(row) < ROW_OFS + IMG_ROWS);
        first_win = (int'(col) == COL_OFS) && (int'(row) == ROW_OFS);
        last_win  = (int'(col) == COL_OFS + IMG_COLS - 1) &&
                    (int'(row) == ROW_OFS + IMG_ROWS - 1);
    end

endmodule

// File: rtl/oled_fb_reader.sv
// Frame-buffer to OLED pixel fetch: one BRAM read per window pixel, border colour
// elsewhere, with an optional freeze handshake towards the capture side.
module oled_fb_reader
    import oled_fb_pkg::*;
#(
    parameter int          OLED_COLS    = OLED_W,
    parameter int          OLED_ROWS    = OLED_H,
    parameter int          IMG_COLS     = IMG_W,
    parameter int          IMG_ROWS     = IMG_H,
    parameter int          COL_OFS      = WIN_COL0,
    parameter int          ROW_OFS      = WIN_ROW0,
    parameter int          ADDR_W       = 13,
    parameter logic [15:0] BORDER_COLOR = 16'h0000,
    parameter int          TO_W         = 20
) (
    input  logic              oclk,
    input  logic              rst,
    input  logic              next_pixel,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [15:0]       fb_pxl,
    input  logic              swap_rb,
    input  logic              hold_en,
    output logic              hold_req,
    input  logic              hold_ack,
    output logic [15:0]       color,
    output logic              frame_done,
    output logic              hold_timeout,
    output logic              overrun
);

    fb_state_t         state;
    logic [ADDR_W-1:0] run_addr;
    logic [ADDR_W-1:0] addr_now;
    logic [TO_W-1:0]   to_cnt;
    logic              border;
    logic              done_pend;
    logic              advance;
    logic              at_origin;
    logic              in_win;
    logic              first_win;
    logic              last_win;

    assign advance = (state == READY) && next_pixel;

    // The running address restarts on the same cycle the origin is fetched.
    assign addr_now = at_origin ? '0 : run_addr;

    oled_scan_counter #(
        .OLED_COLS(OLED_COLS),
        .OLED_ROWS(OLED_ROWS),
        .IMG_COLS (IMG_COLS),
        .IMG_ROWS (IMG_ROWS),
        .COL_OFS  (COL_OFS),
        .ROW_OFS  (ROW_OFS)
    ) u_scan (
        .oclk     (oclk),
        .rst      (rst),
        .advance  (advance),
        .at_origin(at_origin),
        .in_win   (in_win),
        .first_win(first_win),
        .last_win (last_win)
    );

    always_ff @(posedge oclk) begin
        if (rst) begin
            state        <= FETCH;
            run_addr     <= '0;
            to_cnt       <= '0;
            fb_addr      <= '0;
            color        <= BORDER_COLOR;
            border       <= 1'b0;
            done_pend    <= 1'b0;
            hold_req     <= 1'b0;
            frame_done   <= 1'b0;
            hold_timeout <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            done_pend  <= 1'b0;
            if (done_pend) begin
                frame_done <= 1'b1;
                hold_req   <= 1'b0;
            end
            if (next_pixel && (state != READY))
                overrun <= 1'b1;

            case (state)
                FETCH: begin
                    if (at_origin) begin
                        run_addr <= '0;
                        hold_req <= hold_en;
                    end
                    if (!in_win) begin
                        border <= 1'b1;
                        state  <= LATCH;
                    end else if (first_win && hold_en) begin
                        to_cnt <= '0;
                        state  <= HOLD;
                    end else begin
                        fb_addr  <= addr_now;
                        run_addr <= addr_now + 1'b1;
                        border   <= 1'b0;
                        state    <= WAIT;
                    end
                end
                HOLD: begin
                    if (hold_ack || (&to_cnt)) begin
                        if (!hold_ack)
                            hold_timeout <= 1'b1;
                        fb_addr  <= run_addr;
                        run_addr <= run_addr + 1'b1;
                        border   <= 1'b0;
                        state    <= WAIT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT: state <= LATCH;
                LATCH: begin
                    if (border)
                        color <= BORDER_COLOR;
                    else
                        color <= swap_rb ? swap565(fb_pxl) : fb_pxl;
                    if (!border && last_win)
                        done_pend <= 1'b1;
                    state <= READY;
                end
                READY: begin
                    if (next_pixel)
                        state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_fb_reader.sv
// Randomised bench for oled_fb_reader against a position/address arithmetic model.
module tb_oled_fb_reader;

    localparam int OC       = 96;
    localparam int ORW      = 64;
    localparam int IC       = 80;
    localparam int IR       = 60;
    localparam int CO       = 8;
    localparam int RO       = 2;
    localparam int TO_W     = 7;
    localparam int TL       = 1 << TO_W;
    localparam int NPOS     = OC * ORW;
    localparam int LAST_POS = (RO + IR - 1) * OC + (CO + IC - 1);
    localparam logic [15:0] BORDER = 16'h0000;

    logic        oclk = 1'b0;
    logic        rst = 1'b1;
    logic        next_pixel = 1'b0;
    logic        swap_rb = 1'b0;
    logic        hold_en = 1'b0;
    logic        hold_ack = 1'b0;
    logic [12:0] fb_addr;
    logic [15:0] fb_pxl;
    logic [15:0] color;
    logic        hold_req;
    logic        frame_done;
    logic        hold_timeout;
    logic        overrun;

    logic [15:0] mem [0:8191];

    int checks = 0;
    int errors = 0;
    int pos, last_addr, ack_delay, done_cnt, base, dbl_at, target;
    bit hold_frame, ovr_exp, tmo_exp, phase_a;

    oled_fb_reader #(.TO_W(TO_W)) dut (
        .oclk        (oclk),
        .rst         (rst),
        .next_pixel  (next_pixel),
        .fb_addr     (fb_addr),
        .fb_pxl      (fb_pxl),
        .swap_rb     (swap_rb),
        .hold_en     (hold_en),
        .hold_req    (hold_req),
        .hold_ack    (hold_ack),
        .color       (color),
        .frame_done  (frame_done),
        .hold_timeout(hold_timeout),
        .overrun     (overrun)
    );

    always #5 oclk = ~oclk;

    always @(posedge oclk) fb_pxl <= mem[fb_addr];

    initial done_cnt = 0;
    always @(negedge oclk) if (frame_done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sw(input logic [15:0] d);
        return {d[4:0], d[10:5], d[15:11]};
    endfunction

    task automatic do_reset(input bit hen);
        rst = 1'b1;
        next_pixel = 1'b0;
        hold_ack = 1'b0;
        hold_en = hen;
        @(negedge oclk);
        check("rst_hold_req", 32'(hold_req), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_hold_timeout", 32'(hold_timeout), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_color", 32'(color), 32'(BORDER));
        @(negedge oclk);
        rst = 1'b0;
        pos = 0;
        hold_frame = hen;
        ovr_exp = 1'b0;
        tmo_exp = 1'b0;
        last_addr = 0;
        repeat (4) @(negedge oclk);
        check("origin_color", 32'(color), 32'(BORDER));
        check("origin_hold_req", 32'(hold_req), 32'(hen));
    endtask

    // Starts and ends on a falling edge; drives one next_pixel pulse and checks the result.
    task automatic step(input bit dbl);
        int c, r, a;
        bit w, hfirst, stable;
        logic [15:0] d, exp;
        logic [12:0] prev;
        pos = (pos + 1) % NPOS;
        if (pos == 0) hold_frame = hold_en;
        c = pos % OC;
        r = pos / OC;
        w = (c >= CO) && (c < CO + IC) && (r >= RO) && (r < RO + IR);
        a = w ? (r - RO) * IC + (c - CO) : 0;
        hfirst = w && hold_en && (c == CO) && (r == RO);
        if (w && a == 100)                      swap_rb = 1'b1;
        else if (w && (a == 101 || a == 0 || a == IC * IR - 1)) swap_rb = 1'b0;
        else                                    swap_rb = 1'($urandom_range(0, 1));
        d = mem[a];
        exp = !w ? BORDER : (swap_rb ? sw(d) : d);

        next_pixel = 1'b1;
        @(negedge oclk);
        next_pixel = 1'b0;
        if (hfirst) begin
            prev = 13'(last_addr);
            stable = 1'b1;
            repeat ((ack_delay == 0) ? TL : ack_delay) begin
                @(negedge oclk);
                if (fb_addr !== prev || hold_timeout !== tmo_exp) stable = 1'b0;
            end
            check("hold_stall", 32'(stable), 32'd1);
            if (ack_delay != 0) hold_ack = 1'b1;
            else                tmo_exp = 1'b1;
        end
        @(negedge oclk);
        if (dbl) begin
            next_pixel = 1'b1;
            ovr_exp = 1'b1;
        end
        if (w) begin
            check("fb_addr", 32'(fb_addr), 32'(a));
            last_addr = a;
        end
        check("hold_timeout", 32'(hold_timeout), 32'(tmo_exp));
        @(negedge oclk);
        next_pixel = 1'b0;
        @(negedge oclk);
        check("color", 32'(color), 32'(exp));
        check("overrun", 32'(overrun), 32'(ovr_exp));
        check("hold_req", 32'(hold_req), 32'(hold_frame && pos <= LAST_POS));
        if (phase_a && w && a == 0)          check("first_px", 32'(color), 32'd0);
        if (phase_a && w && a == IC*IR - 1)  check("last_px", 32'(color), 32'd4799);
        if (phase_a && w && a == 100)        check("swap_on", 32'(color), 32'h001F);
        if (phase_a && w && a == 101)        check("swap_off", 32'(color), 32'hF800);
        if (pos == LAST_POS) begin
            check("frame_done_early", 32'(frame_done), 32'd0);
            @(negedge oclk);
            check("frame_done", 32'(frame_done), 32'd1);
            check("hold_req_fall", 32'(hold_req), 32'd0);
        end
        if ($urandom_range(0, 7) == 0) @(negedge oclk);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 16'(i);
        mem[100] = 16'hF800;
        mem[101] = 16'hF800;
        ack_delay = 0;
        phase_a = 1'b1;

        // Free-running frame, no handshake, one overrun pulse somewhere mid-frame
        do_reset(1'b0);
        dbl_at = $urandom_range(300, 6000);
        base = done_cnt;
        for (int k = 0; k < NPOS; k++) step(k == dbl_at);
        check("done_count_a", 32'(done_cnt - base), 32'd1);

        // Handshake frame where the ack never comes
        phase_a = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        do_reset(1'b1);
        base = done_cnt;
        for (int k = 0; k < NPOS; k++) step(1'b0);
        check("done_count_b", 32'(done_cnt - base), 32'd1);

        // Acked frame, interrupted by reset at (40,30)
        ack_delay = 100;
        target = 30 * OC + 40;
        while (pos != target) step(pos == 1000);
        check("req_before_rst", 32'(hold_req), 32'd1);
        do_reset(1'b0);
        while (pos != RO * OC + CO) step(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
